mul_iter: RTL and testbench

- Parametrised iterative integer multiplier for the execute stage. Implements RV32/RV64 M-extension multiply: MUL, MULH, MULHSU and MULHU.
- Splits each operand into DW-bit digits and feeds one digit-pair product per cycle through a single (DW+1)x(DW+1) signed multiplier into a wide accumulator.
- Latency trades against area through DW.
- Speaks the pipeline's enable/hold/stall protocol, so it drops in where the fixed 32-bit 16x16 multiplier sits today.

---
 rtl/mul_iter_if.sv | 21 ++
 rtl/mul_iter.sv | 112 +++++++++++
 tb/tb_mul_iter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/mul_iter_if.sv
// rtl/mul_iter_if.sv - pipeline-side request/result bundle for the iterative multiplier
interface mul_iter_if #(parameter int XLEN = 32);
   logic            stall;
   logic            enable_i;
   logic [XLEN-1:0] first_operand_i;
   logic [XLEN-1:0] second_operand_i;
   logic [1:0]      signed_mode_i;
   logic            mul_low_i;
   logic            hold_o;
   logic [XLEN-1:0] result_o;

   modport master (
      output stall, enable_i, first_operand_i, second_operand_i, signed_mode_i, mul_low_i,
      input  hold_o, result_o
   );

   modport slave (
      input  stall, enable_i, first_operand_i, second_operand_i, signed_mode_i, mul_low_i,
      output hold_o, result_o
   );
endinterface

// File: rtl/mul_iter.sv
// rtl/mul_iter.sv - iterative digit-serial M-extension multiplier (MUL/MULH/MULHSU/MULHU)
// Optional operand/product cache enabled by defining MUL_OPCACHE_EN.
module mul_iter #(
   parameter int XLEN = 32,
   parameter int DW   = 16
) (
   input logic        clk,
   input logic        reset_n,
   mul_iter_if.slave  bus
);
   localparam int N      = XLEN / DW;
   localparam int S_FULL = N * N;
   localparam int S_LOW  = N * (N + 1) / 2;
   localparam int CW     = $clog2(2 * N * N + 1);
   localparam int ACC_W  = 2 * XLEN + 2;
   localparam int PW     = 2 * DW + 2;

   logic [CW-1:0]           step_q, diag_q, idx_q;
   logic [CW-1:0]           diag_d, idx_d, diag_nx, idx_top, jdx;
   logic [DW:0]             a_dig, b_dig;
   logic signed [PW-1:0]    a_w, b_w, prod;
   logic signed [ACC_W-1:0] acc_q, p_sh, sum;
   logic [2*XLEN-1:0]       prod_sel;
   logic                    last_step, last, hit, done;

   // Digit-pair product: only the top digit of a signed operand carries its sign.
   always_comb begin
      jdx   = diag_q - idx_q;
      a_dig = {1'b0, bus.first_operand_i[int'(idx_q) * DW +: DW]};
      b_dig = {1'b0, bus.second_operand_i[int'(jdx) * DW +: DW]};
      if (int'(idx_q) == N - 1)
         a_dig[DW] = bus.signed_mode_i[0] & bus.first_operand_i[XLEN-1];
      if (int'(jdx) == N - 1)
         b_dig[DW] = bus.signed_mode_i[1] & bus.second_operand_i[XLEN-1];
      a_w  = PW'($signed(a_dig));
      b_w  = PW'($signed(b_dig));
      prod = a_w * b_w;
      p_sh = ACC_W'(prod) <<< (int'(diag_q) * DW);
      sum  = acc_q + p_sh;
   end

   // Walk diagonals in ascending order, and i ascending within a diagonal.
   always_comb begin
      idx_top = (int'(diag_q) > N - 1) ? CW'(N - 1) : diag_q;
      diag_nx = diag_q + CW'(1);
      diag_d  = diag_q;
      idx_d   = idx_q + CW'(1);
      if (idx_q >= idx_top) begin
         diag_d = diag_nx;
         idx_d  = (int'(diag_nx) > N - 1) ? diag_nx - CW'(N - 1) : '0;
      end
   end

`ifdef MUL_OPCACHE_EN
   logic              c_valid;
   logic [XLEN-1:0]   c_a, c_b;
   logic [1:0]        c_mode;
   logic [2*XLEN-1:0] c_prod;

   // Low halves are sign-mode independent, so a low op may reuse any cached product.
   assign hit = c_valid && (step_q == '0)
             && (bus.first_operand_i == c_a) && (bus.second_operand_i == c_b)
             && (bus.mul_low_i || (bus.signed_mode_i == c_mode));
   assign prod_sel = hit ? c_prod : sum[2*XLEN-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         c_valid <= 1'b0;
         c_a     <= '0;
         c_b     <= '0;
         c_mode  <= '0;
         c_prod  <= '0;
      end else if (done && !bus.mul_low_i && !hit) begin
         c_valid <= 1'b1;
         c_a     <= bus.first_operand_i;
         c_b     <= bus.second_operand_i;
         c_mode  <= bus.signed_mode_i;
         c_prod  <= sum[2*XLEN-1:0];
      end
   end
`else
   assign hit      = 1'b0;
   assign prod_sel = sum[2*XLEN-1:0];
`endif

   assign last_step = bus.mul_low_i ? (step_q == CW'(S_LOW - 1)) : (step_q == CW'(S_FULL - 1));
   assign last      = last_step | hit;
   assign done      = bus.enable_i & last & ~bus.stall;
   assign bus.hold_o   = bus.enable_i & ~last;
   assign bus.result_o = !(bus.enable_i && last) ? '0 :
                         bus.mul_low_i ? prod_sel[XLEN-1:0] : prod_sel[2*XLEN-1:XLEN];

   // A stalled last step simply falls through every branch and keeps its state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         step_q <= '0;
         diag_q <= '0;
         idx_q  <= '0;
         acc_q  <= '0;
      end else if (!bus.enable_i || done) begin
         step_q <= '0;
         diag_q <= '0;
         idx_q  <= '0;
         acc_q  <= '0;
      end else if (!last) begin
         step_q <= step_q + CW'(1);
         diag_q <= diag_d;
         idx_q  <= idx_d;
         acc_q  <= sum;
      end
   end
endmodule

// File: tb/tb_mul_iter.sv
// tb/tb_mul_iter.sv - scoreboard bench for mul_iter (XLEN=32, DW=16)
module tb_mul_iter;
   localparam int XLEN = 32;

`ifdef MUL_OPCACHE_EN
   localparam int CACHE_LAT = 1;
`else
   localparam int CACHE_LAT = 3;
`endif

   typedef struct {
      logic [XLEN-1:0] res;
      int              lat;
      string           name;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   mul_iter_if #(.XLEN(XLEN)) bus ();
   mul_iter #(.XLEN(XLEN), .DW(16)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   mon_cyc  = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: completion is enable && !hold && !stall; stalled last steps must hold the result.
   always @(negedge clk) begin
      exp_t e;
      if (!reset_n || !bus.enable_i) begin
         mon_cyc = 0;
      end else if (!bus.hold_o) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_result: got 0x%0h, expected no completion", bus.result_o);
         end else if (bus.stall) begin
            check({sb[0].name, " stalled"}, 64'(bus.result_o), 64'(sb[0].res));
            mon_cyc++;
         end else begin
            e = sb.pop_front();
            check(e.name, 64'(bus.result_o), 64'(e.res));
            check({e.name, " latency"}, 64'(mon_cyc + 1), 64'(e.lat));
            mon_cyc = 0;
         end
      end else begin
         mon_cyc++;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] mode, input logic low);
      bus.first_operand_i  = a;
      bus.second_operand_i = b;
      bus.signed_mode_i    = mode;
      bus.mul_low_i        = low;
      bus.enable_i         = 1'b1;
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] mode,
                        input logic low, input logic [31:0] res, input int lat, input string name);
      exp_t e;
      e.res  = res;
      e.lat  = lat;
      e.name = name;
      sb.push_back(e);
      set_op(a, b, mode, low);
   endtask

   task automatic wait_done(input string name);
      bit ok = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.enable_i && !bus.hold_o && !bus.stall) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: no completion within 40 cycles", name);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.enable_i = 1'b0;
      cycles(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset_n              = 1'b0;
      bus.stall            = 1'b0;
      bus.enable_i         = 1'b0;
      bus.first_operand_i  = '0;
      bus.second_operand_i = '0;
      bus.signed_mode_i    = 2'b00;
      bus.mul_low_i        = 1'b0;
      #1;
      check("reset hold idle", 64'(bus.hold_o), 64'd0);
      check("reset result idle", 64'(bus.result_o), 64'd0);
      set_op(32'h1, 32'h1, 2'b00, 1'b1);
      #1;
      check("reset hold enabled", 64'(bus.hold_o), 64'd1);
      check("reset result enabled", 64'(bus.result_o), 64'd0);
      bus.enable_i = 1'b0;
      cycles(2);
      reset_n = 1'b1;
      cycles(1);

      issue(32'h00010003, 32'h00020005, 2'b00, 1'b1, 32'h000B000F, 3, "mul_basic");
      wait_done("mul_basic");
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 1'b0, 32'hFFFFFFFE, 4, "mulhu_ones");
      wait_done("mulhu_ones");
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b11, 1'b0, 32'h00000000, 4, "mulh_ones");
      wait_done("mulh_ones");
      issue(32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 1'b0, 32'hFFFFFFFF, 4, "mulhsu_ones");
      wait_done("mulhsu_ones");
      issue(32'h80000000, 32'h80000000, 2'b11, 1'b0, 32'h40000000, 4, "mulh_min");
      wait_done("mulh_min");
      idle();

      // Stall raised on the last step for three cycles, then a back-to-back op.
      issue(32'h00020000, 32'hFFFF0000, 2'b11, 1'b0, 32'hFFFFFFFE, 7, "mulh_stall");
      cycles(3);
      bus.stall = 1'b1;
      cycles(3);
      bus.stall = 1'b0;
      wait_done("mulh_stall");
      issue(32'h80000000, 32'h00000004, 2'b00, 1'b0, 32'h00000002, 4, "mulhu_b2b");
      wait_done("mulhu_b2b");
      idle();

      // Reset at step 1 of a MULH.
      set_op(32'h12345678, 32'h9ABCDEF0, 2'b11, 1'b0);
      cycles(1);
      reset_n = 1'b0;
      #1;
      check("midop reset hold", 64'(bus.hold_o), 64'd1);
      check("midop reset result", 64'(bus.result_o), 64'd0);
      bus.enable_i = 1'b0;
      cycles(1);
      reset_n = 1'b1;
      issue(32'd7, 32'd6, 2'b00, 1'b1, 32'h0000002A, 3, "mul_after_reset");
      wait_done("mul_after_reset");
      idle();

      // Abandon at step 2, then reissue with full latency.
      set_op(32'hFFFFFFFE, 32'h00000003, 2'b01, 1'b0);
      cycles(2);
      idle();
      issue(32'hFFFFFFFE, 32'h00000003, 2'b01, 1'b0, 32'hFFFFFFFF, 4, "mulhsu_reissue");
      wait_done("mulhsu_reissue");
      idle();

      issue(32'h12345678, 32'h9ABCDEF0, 2'b11, 1'b0, 32'hF8CC93D6, 4, "fused_mulh");
      wait_done("fused_mulh");
      issue(32'h12345678, 32'h9ABCDEF0, 2'b11, 1'b1, 32'h242D2080, CACHE_LAT, "fused_mul");
      wait_done("fused_mul");
      idle();

      cycles(3);
      check("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
